// File: rtl/led_scroll_driver.sv
// Multi-digit common-anode 7-segment driver with message buffer and scroll.
// Ports: clk, reset, char_in/char_valid/char_ready, msg_clear, scroll_en, an, seg.
module led_scroll_driver #(
  parameter int DIGITS        = 4,
  parameter int DEPTH         = 16,
  parameter int REFRESH_TICKS = 50000,
  parameter int SCROLL_TICKS  = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              msg_clear,
  input  logic              scroll_en,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(DEPTH + DIGITS) + 1;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

  localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [KW-1:0] K_MAX    = KW'(DIGITS - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(REFRESH_TICKS - 1);
  localparam logic [SW-1:0] S_MAX    = SW'(SCROLL_TICKS - 1);
  localparam logic [3:0]    SPACE    = 4'd12;

  logic [3:0]        msg_buf [DEPTH];
  logic [CW-1:0]     count;
  logic [CW-1:0]     wptr;
  logic [CW-1:0]     offset;
  logic [KW-1:0]     k;
  logic [RW-1:0]     ref_cnt;
  logic [SW-1:0]     sc_cnt;
  logic              started;

  logic              ref_wrap;
  logic              sc_wrap;
  logic              wr;
  logic              long_msg;
  logic [KW-1:0]     k_n;
  logic [IW-1:0]     idx;
  logic [3:0]        code;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      4'd10:   decode = 7'b1111110;
      4'd11:   decode = 7'b0111000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign char_ready = (count != DEPTH_C);
  assign wr         = char_valid & char_ready & ~msg_clear;
  assign long_msg   = (count > DIGITS_C);
  assign ref_wrap   = (ref_cnt == R_MAX);
  assign sc_wrap    = (sc_cnt == S_MAX);

  always_comb begin
    k_n = k;
    if (ref_wrap)
      k_n = (k == K_MAX) ? '0 : k + 1'b1;
  end

  // Character for the digit that will be lit after this edge.
  // Long messages wrap circularly; short ones pad with spaces.
  always_comb begin
    idx  = IW'(offset) + IW'(k_n);
    code = SPACE;
    if (idx >= IW'(count)) begin
      if (long_msg) begin
        idx  = idx - IW'(count);
        code = msg_buf[idx[PW-1:0]];
      end
    end else begin
      code = msg_buf[idx[PW-1:0]];
    end
  end

  always_comb begin
    an_n = '1;
    for (int i = 0; i < DIGITS; i++)
      if (k_n == KW'(DIGITS - 1 - i))
        an_n[i] = 1'b0;
    seg_n = decode(code);
  end

  always_ff @(posedge clk) begin
    if (!reset && wr)
      msg_buf[wptr[PW-1:0]] <= char_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wptr    <= '0;
      offset  <= '0;
      k       <= '0;
      ref_cnt <= '0;
      sc_cnt  <= '0;
      started <= 1'b0;
      an      <= '1;
      seg     <= 7'h7F;
    end else begin
      started <= 1'b1;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      k       <= k_n;
      // Digit outputs latch together with k; the first edge after
      // reset lights digit 0 without waiting for a refresh wrap.
      if (ref_wrap || !started) begin
        an  <= an_n;
        seg <= seg_n;
      end
      if (msg_clear) begin
        count  <= '0;
        wptr   <= '0;
        offset <= '0;
        sc_cnt <= '0;
      end else begin
        if (wr) begin
          count <= count + 1'b1;
          wptr  <= wptr + 1'b1;
        end
        if (!scroll_en || !long_msg)
          sc_cnt <= '0;
        else
          sc_cnt <= sc_wrap ? '0 : sc_cnt + 1'b1;
        if (!long_msg)
          offset <= '0;
        else if (scroll_en && sc_wrap)
          offset <= (offset == count - 1'b1) ? '0 : offset + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_scroll_driver.sv
// Directed self-checking bench for led_scroll_driver.
// DIGITS=4, DEPTH=8, REFRESH_TICKS=4, SCROLL_TICKS=32.
module tb_led_scroll_driver;

  logic       clk;
  logic       reset;
  logic [3:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       msg_clear;
  logic       scroll_en;
  logic [3:0] an;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  logic [6:0] dec [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b0111000,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  logic [3:0] msg [8] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11
  };

  led_scroll_driver #(
    .DIGITS(4), .DEPTH(8), .REFRESH_TICKS(4), .SCROLL_TICKS(32)
  ) dut (
    .clk(clk), .reset(reset),
    .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .msg_clear(msg_clear),
    .scroll_en(scroll_en), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] c);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic clear();
    msg_clear = 1'b1;
    @(negedge clk);
    msg_clear = 1'b0;
  endtask

  task automatic read_digit(input int k, output logic [6:0] s);
    logic [3:0] pat;
    int n;
    pat = ~(4'b1000 >> k);
    n = 0;
    while (an !== pat && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("an_wait_d%0d", k), an, pat);
    s = seg;
  endtask

  // codes packed {d0,d1,d2,d3}; 12 = space
  task automatic check_window(input string tag, input logic [15:0] codes);
    logic [6:0] s;
    logic [3:0] c;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      read_digit(k, s);
      c = codes[15 - 4*k -: 4];
      check($sformatf("%s_d%0d", tag, k), s, dec[c]);
    end
  endtask

  initial begin
    logic [6:0] s;
    logic [15:0] w;
    reset      = 1'b1;
    char_in    = '0;
    char_valid = 1'b0;
    msg_clear  = 1'b0;
    scroll_en  = 1'b0;

    // 1: reset state and anode rotation
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    check("rst_ready", char_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("rot0", an, 4'b0111);
    repeat (4) @(negedge clk);
    check("rot1", an, 4'b1011);
    repeat (4) @(negedge clk);
    check("rot2", an, 4'b1101);
    repeat (4) @(negedge clk);
    check("rot3", an, 4'b1110);
    repeat (4) @(negedge clk);
    check("rot4", an, 4'b0111);

    // 2: short message padded with spaces
    load(4'd1);
    load(4'd2);
    load(4'd3);
    check_window("short", {4'd1, 4'd2, 4'd3, 4'd12});

    // 3: fill buffer with valid held; 9th write dropped
    clear();
    char_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      char_in = msg[i];
      if (i == 7) check("ready_before_full", char_ready, 1'b1);
      @(negedge clk);
    end
    check("ready_full", char_ready, 1'b0);
    char_in = 4'd9;
    @(negedge clk);
    char_valid = 1'b0;
    check("ready_still_full", char_ready, 1'b0);
    check_window("full", {4'd0, 4'd1, 4'd2, 4'd3});

    // 4: one scroll step per 32-cycle burst of scroll_en
    for (int st = 1; st <= 8; st++) begin
      scroll_en = 1'b1;
      repeat (32) @(negedge clk);
      scroll_en = 1'b0;
      w = {msg[st % 8], msg[(st + 1) % 8],
           msg[(st + 2) % 8], msg[(st + 3) % 8]};
      check_window($sformatf("scroll%0d", st), w);
    end

    // 5: clear beats a simultaneous write
    char_in    = 4'd5;
    char_valid = 1'b1;
    msg_clear  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    msg_clear  = 1'b0;
    check("clr_ready", char_ready, 1'b1);
    check_window("cleared", {4'd12, 4'd12, 4'd12, 4'd12});
    load(4'd8);
    check_window("after_clr", {4'd8, 4'd12, 4'd12, 4'd12});

    // 6: reset mid-scroll
    clear();
    for (int i = 0; i < 8; i++) load(msg[i]);
    scroll_en = 1'b1;
    repeat (45) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_ready", char_ready, 1'b1);
    scroll_en = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 8; i++) load(msg[i]);
    check_window("post_rst", {4'd0, 4'd1, 4'd2, 4'd3});

    // decode sweep on digit 0
    for (int c = 0; c < 16; c++) begin
      clear();
      load(4'(c));
      repeat (20) @(negedge clk);
      read_digit(0, s);
      check($sformatf("sweep%0d", c), s, dec[c]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
